shift_reg_universal: RTL and testbench
======================================

Name: shift_reg_universal

Overview:
Parametrised universal shift register. Successor to the fixed 4-bit PIPO register.
Adds selectable parallel load, logical/arithmetic shifts, rotates, serial in/out, clock enable, and a shift counter with a word-complete pulse.
Used as the common serialise/deserialise and data-alignment element in datapath blocks.

Parameters:
WIDTH, 4, register width in bits; legal range 2..64.
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
en  input  1  clock enable; 0 = every register holds
mode  input  3  operation select, sampled at posedge clk when en=1
d  input  WIDTH  parallel load data
sin_r  input  1  serial in, enters bit 0 on shift-left
sin_l  input  1  serial in, enters bit WIDTH-1 on shift-right
q  output  WIDTH  register contents
sout_l  output  1  equals q[WIDTH-1]; combinational from q
sout_r  output  1  equals q[0]; combinational from q
shift_cnt  output  CNT_W  shifts since last load/clear, saturating; CNT_W = $clog2(WIDTH+1)
word_done  output  1  one-cycle pulse when shift_cnt reaches WIDTH

Behaviour:
- Reset is asynchronous: the instant reset=1, q=RESET_VAL, shift_cnt=0, word_done=0. Reset dominates en and mode, including mid-operation.
- All updates occur on posedge clk, with 1-cycle latency from inputs to q.
- en=0: q and shift_cnt hold; word_done=0.
- mode encoding, applied when en=1:
  - 000 HOLD: q unchanged, shift_cnt unchanged.
  - 001 LOAD: q<=d; shift_cnt<=0.
  - 010 SHL: q<={q[WIDTH-2:0],sin_r}.
  - 011 SHR: q<={sin_l,q[WIDTH-1:1]}.
  - 100 ROL: q<={q[WIDTH-2:0],q[WIDTH-1]}.
  - 101 ROR: q<={q[0],q[WIDTH-1:1]}.
  - 110 ASR: q<={q[WIDTH-1],q[WIDTH-1:1]}; the sign bit is replicated.
  - 111 CLEAR: q<=0 (not RESET_VAL); shift_cnt<=0.
- Counting ops are 010..110. Each counting op with en=1 increments shift_cnt, saturating at WIDTH. Once at WIDTH, further shifts leave it at WIDTH.
- word_done is registered. It is 1 for exactly the cycle after the edge on which shift_cnt goes WIDTH-1 -> WIDTH, and 0 otherwise. It does not re-fire while saturated.
- A LOAD or CLEAR on the same edge that would have completed the word wins: shift_cnt=0, word_done=0.
- All modes are defined, so there is no illegal encoding. Undriven or X mode is a bench error and is not handled in RTL.
- No combinational path from inputs to q. sout_l and sout_r derive only from q.

Decomposition:
- Package shift_reg_pkg holds the mode localparams: MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR.
- Optional sub-module shift_cnt_sat holds the saturating counter plus the done-pulse logic (parameter MAX=WIDTH).
- The data path stays in the top module as a single case statement.

Test Plan (WIDTH=4, RESET_VAL=0 unless noted):
- Async reset: with q=1010, raise reset between edges -> q=0000, shift_cnt=0, word_done=0 immediately, with no clock edge needed. With RESET_VAL=4'b0101, reset -> q=0101.
- Load and hold: LOAD d=1011 -> q=1011, shift_cnt=0. Then en=0 with mode=LOAD, d=0000 for 3 cycles -> q stays 1011.
- SHL with sin_r=1 from 1011, 5 edges -> q sequence 0111, 1111, 1111, 1111, 1111; shift_cnt 1,2,3,4,4; word_done high only after the 4th edge.
- ROR from 1001, 4 edges -> 1100, 0110, 0011, 1001; sout_r follows q[0]; word_done pulses once.
- ASR from 1000, 2 edges -> 1100, 1110. SHR with sin_l=0 from 1000 -> 0100.
- Completion collision: shift_cnt=3, then LOAD d=0110 -> q=0110, shift_cnt=0, no word_done. CLEAR from 1111 -> q=0000, shift_cnt=0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the classification of which operations advance the shift counter.
package shift_reg_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_CLR  = 3'b111;

   // Every bit-moving operation counts towards a completed word.
   function automatic logic is_count_mode(input logic [MODE_W-1:0] mode);
      return (mode >= MODE_SHL) && (mode <= MODE_ASR);
   endfunction

   // LOAD and CLEAR both start a fresh word.
   function automatic logic is_restart_mode(input logic [MODE_W-1:0] mode);
      return (mode == MODE_LOAD) || (mode == MODE_CLR);
   endfunction

endpackage

// File: rtl/shift_cnt_sat.sv
// Saturating shift counter with a registered one-cycle pulse on the edge
// where the count first reaches MAX.
module shift_cnt_sat #(
   parameter  int MAX   = 4,
   localparam int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             done_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;

   always_comb begin
      // NOTE: every signal gets a default before the branches so no path
      // leaves it unassigned, which would otherwise infer a latch.
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (en_i) begin
         if (clr_i) begin
            cnt_d = '0;
         end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == CNT_LAST);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign done_o = done_q;

endmodule

// File: rtl/shift_reg_universal.sv
// Parametrised universal shift register: parallel load, logical/arithmetic
// shifts, rotates, serial in/out, clock enable and a word-complete counter.
module shift_reg_universal
   import shift_reg_pkg::*;
#(
   parameter  int               WIDTH     = 4,
   parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_r,
   input  logic              sin_l,
   output logic [WIDTH-1:0]  q,
   output logic              sout_l,
   output logic              sout_r,
   output logic [CNT_W-1:0]  shift_cnt,
   output logic              word_done
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         case (mode)
            MODE_HOLD: q_d = q_q;
            MODE_LOAD: q_d = d;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
            MODE_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
            MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_ASR:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            MODE_CLR:  q_d = '0;  // deliberately zero, not RESET_VAL
            default:   q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= RESET_VAL;
      else       q_q <= q_d;
   end

   shift_cnt_sat #(
      .MAX (WIDTH)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en),
      .clr_i  (is_restart_mode(mode)),
      .inc_i  (is_count_mode(mode)),
      .cnt_o  (shift_cnt),
      .done_o (word_done)
   );

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Self-checking bench for shift_reg_universal (WIDTH=4): a reference model
// pushes expected state per edge to a scoreboard that is popped after the edge.
module tb_shift_reg_universal;
   import shift_reg_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] d;
   logic         sin_r, sin_l;
   logic [W-1:0] q, q_rv;
   logic         sout_l, sout_r, sout_l_rv, sout_r_rv;
   logic [2:0]   shift_cnt, shift_cnt_rv;
   logic         word_done, word_done_rv;

   int n_vectors     = 0;
   int n_miscompares = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [2:0]   cnt;
      logic         done;
   } exp_t;

   exp_t sb_q[$];

   logic [W-1:0] m_q;
   logic [2:0]   m_cnt;
   logic         m_done;

   shift_reg_universal #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_l(sout_l), .sout_r(sout_r),
      .shift_cnt(shift_cnt), .word_done(word_done)
   );

   shift_reg_universal #(.WIDTH(W), .RESET_VAL(4'b0101)) dut_rv (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d),
      .sin_r(sin_r), .sin_l(sin_l), .q(q_rv), .sout_l(sout_l_rv), .sout_r(sout_r_rv),
      .shift_cnt(shift_cnt_rv), .word_done(word_done_rv)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q    = 4'b0000;
      m_cnt  = 3'd0;
      m_done = 1'b0;
   endtask

   // Behavioural reference for one clock edge.
   task automatic model_edge(input logic e, input logic [2:0] m, input logic [W-1:0] dd,
                             input logic sr, input logic sl);
      m_done = 1'b0;
      if (!e) return;
      case (m)
         MODE_LOAD: m_q = dd;
         MODE_SHL:  m_q = (m_q << 1) | W'(sr);
         MODE_SHR:  m_q = (m_q >> 1) | (W'(sl) << (W - 1));
         MODE_ROL:  m_q = (m_q << 1) | (m_q >> (W - 1));
         MODE_ROR:  m_q = (m_q >> 1) | (m_q << (W - 1));
         MODE_ASR:  m_q = W'($signed(m_q) >>> 1);
         MODE_CLR:  m_q = '0;
         default:   ;
      endcase
      if (m == MODE_LOAD || m == MODE_CLR) begin
         m_cnt = 3'd0;
      end else if (m >= MODE_SHL && m <= MODE_ASR && m_cnt < 3'(W)) begin
         m_cnt++;
         m_done = (m_cnt == 3'(W));
      end
   endtask

   // Entered and left on a falling edge; compares just after the rising edge.
   task automatic step(input string tag, input logic e, input logic [2:0] m,
                       input logic [W-1:0] dd, input logic sr, input logic sl);
      exp_t x;
      en = e; mode = m; d = dd; sin_r = sr; sin_l = sl;
      model_edge(e, m, dd, sr, sl);
      sb_q.push_back('{q: m_q, cnt: m_cnt, done: m_done});
      @(posedge clk);
      #1;
      x = sb_q.pop_front();
      check({tag, ".q"},      q,         x.q);
      check({tag, ".cnt"},    shift_cnt, x.cnt);
      check({tag, ".done"},   word_done, x.done);
      check({tag, ".sout_l"}, sout_l,    x.q[W-1]);
      check({tag, ".sout_r"}, sout_r,    x.q[0]);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] shl_q [5];
      logic [2:0]   shl_c [5];
      logic [W-1:0] ror_q [4];
      shl_q = '{4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
      shl_c = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
      ror_q = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

      reset = 1'b1; en = 1'b0; mode = MODE_HOLD; d = '0; sin_r = 1'b0; sin_l = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst.q",     q,         4'b0000);
      check("rst.cnt",   shift_cnt, 3'd0);
      check("rst.done",  word_done, 1'b0);
      check("rst_rv.q",  q_rv,      4'b0101);
      reset = 1'b0;

      // Asynchronous reset between edges, with no clock edge in between.
      step("load_1010", 1'b1, MODE_LOAD, 4'b1010, 1'b0, 1'b0);
      check("pre_arst.q", q, 4'b1010);
      #2 reset = 1'b1;
      #1;
      check("arst.q",    q,         4'b0000);
      check("arst.cnt",  shift_cnt, 3'd0);
      check("arst.done", word_done, 1'b0);
      check("arst_rv.q", q_rv,      4'b0101);
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      // Load, then disabled cycles must hold despite LOAD and new d.
      step("load_1011", 1'b1, MODE_LOAD, 4'b1011, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("en0_hold", 1'b0, MODE_LOAD, 4'b0000, 1'b0, 1'b0);
      check("en0_hold.q_const", q, 4'b1011);
      step("hold_mode", 1'b1, MODE_HOLD, 4'b0000, 1'b0, 1'b0);

      // SHL with sin_r=1: saturation and a single done pulse.
      for (int i = 0; i < 5; i++) begin
         step("shl", 1'b1, MODE_SHL, 4'b0000, 1'b1, 1'b0);
         check("shl.q_const",    q,         shl_q[i]);
         check("shl.cnt_const",  shift_cnt, shl_c[i]);
         check("shl.done_const", word_done, (i == 3));
      end

      // ROR from 1001 returns to the start after a full word.
      step("load_1001", 1'b1, MODE_LOAD, 4'b1001, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step("ror", 1'b1, MODE_ROR, 4'b0000, 1'b0, 1'b0);
         check("ror.q_const",    q,         ror_q[i]);
         check("ror.done_const", word_done, (i == 3));
      end
      step("en0_after_done", 1'b0, MODE_ROR, 4'b0000, 1'b0, 1'b0);

      step("load_1000", 1'b1, MODE_LOAD, 4'b1000, 1'b0, 1'b0);
      step("asr1", 1'b1, MODE_ASR, 4'b0000, 1'b0, 1'b0);
      check("asr1.q_const", q, 4'b1100);
      step("asr2", 1'b1, MODE_ASR, 4'b0000, 1'b0, 1'b0);
      check("asr2.q_const", q, 4'b1110);
      step("load_1000b", 1'b1, MODE_LOAD, 4'b1000, 1'b0, 1'b0);
      step("shr", 1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b0);
      check("shr.q_const", q, 4'b0100);
      step("shr_sin1", 1'b1, MODE_SHR, 4'b0000, 1'b0, 1'b1);
      step("rol", 1'b1, MODE_ROL, 4'b0000, 1'b0, 1'b0);

      // LOAD on the edge that would have completed the word.
      step("load_0000", 1'b1, MODE_LOAD, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("shl_to3", 1'b1, MODE_SHL, 4'b0000, 1'b0, 1'b0);
      check("coll_pre.cnt", shift_cnt, 3'd3);
      step("coll_load", 1'b1, MODE_LOAD, 4'b0110, 1'b0, 1'b0);
      check("coll_load.q_const",    q,         4'b0110);
      check("coll_load.cnt_const",  shift_cnt, 3'd0);
      check("coll_load.done_const", word_done, 1'b0);

      // CLEAR on the completing edge; zero, not RESET_VAL.
      step("load_1111", 1'b1, MODE_LOAD, 4'b1111, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("rol_to3", 1'b1, MODE_ROL, 4'b0000, 1'b0, 1'b0);
      step("coll_clr", 1'b1, MODE_CLR, 4'b0000, 1'b0, 1'b0);
      check("coll_clr.q_const",    q,         4'b0000);
      check("coll_clr.cnt_const",  shift_cnt, 3'd0);
      check("coll_clr.done_const", word_done, 1'b0);
      check("clr_rv.q",            q_rv,      4'b0000);

      // Random traffic against the model.
      for (int i = 0; i < 60; i++) begin
         step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
